// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 3-sample majority voting, false-start rejection, one-entry output hold.
// Optional parity checking is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int H   = OVERSAMPLE / 2;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx_os: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_os_chk
    $error("uart_rx_os: OVERSAMPLE must be even and at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_fmt_chk
    $error("uart_rx_os: unsupported DATA_BITS or STOP_BITS");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
    $error("uart_rx_os: PARITY_ODD must be 0 or 1");
  end

  logic                 rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [2:0]           state_q, state_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic [OW-1:0]        os_q, os_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_acc_q, ferr_acc_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
`endif
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

  logic tick, at_s0, at_s1, at_dec, bit_end, maj;
  logic frame_done, done_ferr, done_perr;

  always_comb begin
    tick    = (state_q != IDLE) && (pre_q == PW'(DIV - 1));
    at_s0   = tick && (os_q == OW'(H - 1));
    at_s1   = tick && (os_q == OW'(H));
    at_dec  = tick && (os_q == OW'(H + 1));
    bit_end = tick && (os_q == OW'(OVERSAMPLE - 1));
    maj     = (samp_q[0] & samp_q[1]) | ((samp_q[0] | samp_q[1]) & rx_s_q);

    rx_meta_d  = rx;
    rx_s_d     = rx_meta_q;
    state_d    = state_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    ferr_acc_d = ferr_acc_q;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    done_perr  = ((^shift_q) ^ par_q) != 1'(PARITY_ODD);
`else
    done_perr  = 1'b0;
`endif
    frame_done = 1'b0;
    done_ferr  = 1'b0;

    // Prescaler and bit-phase counter sit at zero while idle so a start edge aligns them.
    if (state_q == IDLE)  pre_d = '0;
    else if (tick)        pre_d = '0;
    else                  pre_d = pre_q + PW'(1);

    if (state_q == IDLE)  os_d = '0;
    else if (bit_end)     os_d = '0;
    else if (tick)        os_d = os_q + OW'(1);
    else                  os_d = os_q;

    if (at_s0) samp_d[0] = rx_s_q;
    if (at_s1) samp_d[1] = rx_s_q;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d    = START;
          bit_d      = '0;
          stop_d     = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      START: begin
        if (at_dec && maj) state_d = IDLE;
        else if (bit_end)  state_d = DATA;
      end
      DATA: begin
        if (at_dec) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_dec)  par_d   = maj;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // The final stop bit finishes at its decision point so a following start edge is not missed.
        if (at_dec) begin
          if (!maj) ferr_acc_d = 1'b1;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            done_ferr  = ferr_acc_q | ~maj;
            state_d    = IDLE;
          end
        end
        if (bit_end) stop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // valid/ready: a word transfers on any edge where valid && ready; the held word and flags stay
  // stable until then, a completing frame may refill the register in the same cycle it drains,
  // and a frame completing while the register is full and not draining is dropped and flags overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (frame_done) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        perr_d  = done_perr;
        ferr_d  = done_ferr;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      pre_q      <= '0;
      os_q       <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      samp_q     <= '0;
      shift_q    <= '0;
      ferr_acc_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
`endif
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      state_q    <= state_d;
      pre_q      <= pre_d;
      os_q       <= os_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      ferr_acc_q <= ferr_acc_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
`endif
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule
